// File: rtl/t08_mmio_responder.sv
// rtl/t08_mmio_responder.sv - CPU data-memory responder: RAM req/ack port with timeout plus MMIO registers
module t08_mmio_responder #(
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic [31:0] gpio_out,
    input  logic [31:0] gpio_in,
    output logic        bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        gpio_out_q, gpio_out_d;
    logic [31:0]        gpio_meta_q, gpio_sync_q;
    logic [31:0]        cycle_q, cycle_d;
    logic               bus_err_q, bus_err_d;

    logic               err_set;
    logic               err_clr;
    logic               strobe;
    logic               is_mmio;
    logic [29:0]        off_word;
    logic               off_hit;

    // Word offset inside the MMIO window; byte lanes addr[1:0] are ignored.
    assign off_word = cpu_addr[31:2] - MMIO_BASE[31:2];
    assign off_hit  = (off_word[29:2] == '0);
    assign strobe   = cpu_read | cpu_write;
    assign is_mmio  = (cpu_addr >= MMIO_BASE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        gpio_out_d = gpio_out_q;
        cycle_d    = cycle_q + 32'd1;
        err_set    = 1'b0;
        err_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (strobe) begin
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    we_d       = cpu_write;
                    wait_cnt_d = '0;
                    rdata_d    = 32'd0;
                    if (cpu_read && cpu_write) begin
                        err_set = 1'b1;
                    end
                    if (is_mmio) begin
                        state_d = DONE;
                        if (!off_hit) begin
                            err_set = 1'b1;
                        end else begin
                            case (off_word[1:0])
                                2'd0: begin
                                    if (cpu_write) gpio_out_d = cpu_wdata;
                                    else           rdata_d    = gpio_out_q;
                                end
                                2'd1: begin
                                    if (!cpu_write) rdata_d = gpio_sync_q;
                                end
                                2'd2: begin
                                    // A clearing write overrides this cycle's increment.
                                    if (cpu_write) cycle_d = 32'd0;
                                    else           rdata_d = cycle_q;
                                end
                                default: begin
                                    if (cpu_write) err_clr = cpu_wdata[0];
                                    else           rdata_d = {31'd0, bus_err_q};
                                end
                            endcase
                        end
                    end else begin
                        state_d = RAM_WAIT;
                    end
                end
            end
            RAM_WAIT: begin
                // A late ack still beats the timeout in the same cycle.
                if (ram_ack) begin
                    rdata_d = we_q ? 32'd0 : ram_rdata;
                    state_d = DONE;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    rdata_d = ERR_DATA;
                    err_set = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh error raised in the same cycle as a STATUS clear keeps the flag set.
        bus_err_d = err_set | (bus_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            wait_cnt_q  <= '0;
            rdata_q     <= '0;
            gpio_out_q  <= '0;
            gpio_meta_q <= '0;
            gpio_sync_q <= '0;
            cycle_q     <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            wait_cnt_q  <= wait_cnt_d;
            rdata_q     <= rdata_d;
            gpio_out_q  <= gpio_out_d;
            gpio_meta_q <= gpio_in;
            gpio_sync_q <= gpio_meta_q;
            cycle_q     <= cycle_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign cpu_done  = (state_q == DONE);
    assign cpu_busy  = (state_q != IDLE) && (state_q != DONE);
    assign cpu_rdata = cpu_done ? rdata_q : 32'd0;
    assign ram_req   = (state_q == RAM_WAIT);
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign gpio_out  = gpio_out_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_t08_mmio_responder.sv
// tb/tb_t08_mmio_responder.sv - directed self-checking bench for t08_mmio_responder
module tb_t08_mmio_responder;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    t08_mmio_responder #(
        .MMIO_BASE (32'hFFFF_0000),
        .TIMEOUT   (TO),
        .ERR_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_busy  (cpu_busy),
        .cpu_done  (cpu_done),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .gpio_out  (gpio_out),
        .gpio_in   (gpio_in),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU access; ack_at is the ram_req cycle (1-based) in which ram_ack is driven, 0 = never.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_at, input logic [31:0] ack_data,
                             output logic [31:0] rdata, output int lat, output int st,
                             output logic [31:0] req_addr, output logic req_we);
        int  reqn;
        bit  got;
        @(negedge clk);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        st       = cyc;
        reqn     = 0;
        got      = 1'b0;
        rdata    = 32'd0;
        lat      = -1;
        req_addr = 32'd0;
        req_we   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_done) begin
                rdata     = cpu_rdata;
                lat       = cyc - st;
                got       = 1'b1;
                cpu_read  = 1'b0;
                cpu_write = 1'b0;
                ram_ack   = 1'b0;
                break;
            end
            ram_ack = 1'b0;
            if (ram_req) begin
                reqn++;
                if (reqn == 1) begin
                    req_addr = ram_addr;
                    req_we   = ram_we;
                end
                if (reqn == ack_at) begin
                    ram_ack   = 1'b1;
                    ram_rdata = ack_data;
                end
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] ra;
    logic        rw;
    int          lat;
    int          st1;
    int          st2;
    int          rcyc;
    bit          saw_done;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        ram_rdata = 32'd0;
        ram_ack   = 1'b0;
        gpio_in   = 32'h0000_00FF;
        repeat (3) @(negedge clk);
        check("rst_done",  32'(cpu_done), 32'd0);
        check("rst_busy",  32'(cpu_busy), 32'd0);
        check("rst_req",   32'(ram_req),  32'd0);
        check("rst_gpio",  gpio_out,      32'd0);
        check("rst_err",   32'(bus_err),  32'd0);
        check("rst_rdata", cpu_rdata,     32'd0);
        rst = 1'b0;

        // RAM read, ack in the third ram_req cycle
        do_access("ram_rd", 1'b1, 1'b0, 32'h0000_0100, 32'd0, 3, 32'h1234_5678, rd, lat, st1, ra, rw);
        check("ram_rd_data", rd, 32'h1234_5678);
        check("ram_rd_lat",  32'(lat), 32'd4);
        check("ram_rd_addr", ra, 32'h0000_0100);
        check("ram_rd_we",   32'(rw), 32'd0);
        check("ram_rd_req_dropped", 32'(ram_req), 32'd0);
        check("ram_rd_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        check("ram_rd_done_one_cycle", 32'(cpu_done), 32'd0);

        // GPIO write then GPIO_IN read
        do_access("gpio_wr", 1'b0, 1'b1, 32'hFFFF_0000, 32'hA5A5_0001, 0, 32'd0, rd, lat, st1, ra, rw);
        check("gpio_wr_lat", 32'(lat), 32'd1);
        check("gpio_out",    gpio_out, 32'hA5A5_0001);
        do_access("gpio_rd_out", 1'b1, 1'b0, 32'hFFFF_0000, 32'd0, 0, 32'd0, rd, lat, st1, ra, rw);
        check("gpio_rd_out", rd, 32'hA5A5_0001);
        do_access("gpio_in", 1'b1, 1'b0, 32'hFFFF_0004, 32'd0, 0, 32'd0, rd, lat, st1, ra, rw);
        check("gpio_in_data", rd, 32'h0000_00FF);

        // Timeout with no ack, then STATUS read and clear
        do_access("tmo", 1'b1, 1'b0, 32'h0000_0200, 32'd0, 0, 32'd0, rd, lat, st1, ra, rw);
        check("tmo_data", rd, 32'hDEAD_BEEF);
        check("tmo_lat",  32'(lat), 32'(TO + 2));
        check("tmo_err",  32'(bus_err), 32'd1);
        do_access("status_rd", 1'b1, 1'b0, 32'hFFFF_000C, 32'd0, 0, 32'd0, rd, lat, st1, ra, rw);
        check("status_rd", rd, 32'd1);
        do_access("status_clr", 1'b0, 1'b1, 32'hFFFF_000C, 32'd1, 0, 32'd0, rd, lat, st1, ra, rw);
        check("status_clr_err", 32'(bus_err), 32'd0);

        // Ack in the very cycle the wait counter reaches TIMEOUT
        do_access("ack_edge", 1'b1, 1'b0, 32'h0000_0300, 32'd0, TO + 1, 32'h0000_0055, rd, lat, st1, ra, rw);
        check("ack_edge_data", rd, 32'h0000_0055);
        check("ack_edge_lat",  32'(lat), 32'(TO + 2));
        check("ack_edge_err",  32'(bus_err), 32'd0);

        // RAM write returns zero data and drives we
        do_access("ram_wr", 1'b0, 1'b1, 32'h0000_0040, 32'h7777_0000, 2, 32'hFFFF_FFFF, rd, lat, st1, ra, rw);
        check("ram_wr_data", rd, 32'd0);
        check("ram_wr_we",   32'(rw), 32'd1);

        // Cycle counter: clear, idle, read back elapsed count
        do_access("cyc_clr", 1'b0, 1'b1, 32'hFFFF_0008, 32'h1234, 0, 32'd0, rd, lat, st1, ra, rw);
        repeat (7) @(negedge clk);
        do_access("cyc_rd", 1'b1, 1'b0, 32'hFFFF_0008, 32'd0, 0, 32'd0, rd, lat, st2, ra, rw);
        check("cyc_elapsed", rd, 32'(st2 - st1 - 1));

        // Counter wrap from all-ones
        @(negedge clk);
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        do_access("cyc_wrap", 1'b1, 1'b0, 32'hFFFF_0008, 32'd0, 0, 32'd0, rd, lat, st2, ra, rw);
        check("cyc_wrap", rd, 32'd0);

        // Unmapped MMIO offset
        do_access("bad_off", 1'b1, 1'b0, 32'hFFFF_0010, 32'd0, 0, 32'd0, rd, lat, st1, ra, rw);
        check("bad_off_data", rd, 32'd0);
        check("bad_off_err",  32'(bus_err), 32'd1);
        do_access("status_clr2", 1'b0, 1'b1, 32'hFFFF_000C, 32'd1, 0, 32'd0, rd, lat, st1, ra, rw);
        check("status_clr2_err", 32'(bus_err), 32'd0);

        // Both strobes: write happens and error is flagged
        do_access("both", 1'b1, 1'b1, 32'hFFFF_0000, 32'h0BAD_F00D, 0, 32'd0, rd, lat, st1, ra, rw);
        check("both_gpio", gpio_out, 32'h0BAD_F00D);
        check("both_err",  32'(bus_err), 32'd1);

        // Reset in the middle of a RAM wait
        @(negedge clk);
        cpu_read = 1'b1;
        cpu_addr = 32'h0000_0500;
        repeat (3) @(negedge clk);
        check("mid_req_before", 32'(ram_req), 32'd1);
        check("mid_busy_before", 32'(cpu_busy), 32'd1);
        rst      = 1'b1;
        cpu_read = 1'b0;
        @(negedge clk);
        rcyc = cyc;
        check("mid_req",   32'(ram_req),  32'd0);
        check("mid_busy",  32'(cpu_busy), 32'd0);
        check("mid_done",  32'(cpu_done), 32'd0);
        check("mid_gpio",  gpio_out,      32'd0);
        check("mid_err",   32'(bus_err),  32'd0);
        check("mid_rdata", cpu_rdata,     32'd0);
        check("mid_addr",  ram_addr,      32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_done) saw_done = 1'b1;
        end
        check("mid_no_done", 32'(saw_done), 32'd0);
        do_access("post_cyc", 1'b1, 1'b0, 32'hFFFF_0008, 32'd0, 0, 32'd0, rd, lat, st2, ra, rw);
        check("post_rst_cycle", rd, 32'(st2 - rcyc));
        do_access("post_rd", 1'b1, 1'b0, 32'h0000_0400, 32'd0, 1, 32'hCAFE_F00D, rd, lat, st1, ra, rw);
        check("post_rd_data", rd, 32'hCAFE_F00D);
        check("post_rd_lat",  32'(lat), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/t08_mmio_responder.md
Name: t08_mmio_responder

Overview:
- Responder end of the CPU data-memory interface. Accepts the memory handler's read/write requests (address, write data, read/write strobes) and decodes each to external RAM or to a small internal MMIO register file.
- Returns read data and completion to the CPU.
- Drives a single-outstanding req/ack port toward RAM, with a timeout so a dead slave cannot hang the CPU.

Parameters:
- MMIO_BASE, 32'hFFFF_0000, addresses >= MMIO_BASE decode to internal registers; all others go to RAM.
- TIMEOUT, 16, RAM wait cycles before the access is aborted.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- cpu_read  input  1  read request, held until cpu_done
- cpu_write  input  1  write request, held until cpu_done
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  write data
- cpu_rdata  output  32  read data, valid while cpu_done=1
- cpu_busy  output  1  high from acceptance until the cycle before cpu_done
- cpu_done  output  1  one-cycle completion pulse
- ram_req  output  1  RAM request, held until ram_ack or timeout
- ram_we  output  1  1=write, 0=read
- ram_addr  output  32  RAM address (cpu_addr passed through unchanged)
- ram_wdata  output  32  RAM write data
- ram_rdata  input  32  RAM read data, sampled with ram_ack
- ram_ack  input  1  RAM completion, single cycle
- gpio_out  output  32  GPIO_OUT register
- gpio_in  input  32  asynchronous GPIO inputs
- bus_err  output  1  sticky error flag

Behaviour:
- Reset (rst=1 at an edge):
  - State becomes IDLE.
  - All outputs 0, including cpu_rdata, gpio_out, bus_err and the cycle counter.
  - Applies even mid-access: ram_req drops on the next edge and no cpu_done is produced.
- FSM states are IDLE, RAM_WAIT and DONE.
- IDLE:
  - If cpu_read or cpu_write is high, latch the address, write data and we (we = cpu_write).
  - If both strobes are high, perform a write and set bus_err.
  - Address >= MMIO_BASE: perform the register access this cycle, then go to DONE.
  - Otherwise: go to RAM_WAIT with ram_req=1 from the next cycle.
- RAM_WAIT:
  - ram_req, ram_we, ram_addr and ram_wdata stay stable.
  - A wait counter increments each cycle.
  - On ram_ack: capture ram_rdata (reads; writes capture 0) and go to DONE.
  - If the counter reaches TIMEOUT without ack: cpu_rdata=ERR_DATA, set bus_err, go to DONE.
  - ram_ack in the same cycle as the timeout: ack wins.
  - ram_req deasserts in the cycle after ack/timeout.
- DONE: cpu_done=1 and cpu_rdata valid for exactly one cycle, then IDLE.
- Request handshake:
  - The CPU drops its strobe in the cycle cpu_done is seen.
  - A strobe still high in IDLE is accepted as a new access.
  - Strobe changes while busy are ignored.
- Latency: MMIO cpu_done is 1 cycle after acceptance. RAM cpu_done is 1 cycle after the ram_ack cycle.
- cpu_busy = (state != IDLE) && (state != DONE).
- MMIO map (offset = addr - MMIO_BASE; addr[1:0] ignored):
  - 0x0 GPIO_OUT: read/write.
  - 0x4 GPIO_IN: read-only, 2-flop synchronized; writes ignored.
  - 0x8 CYCLE: free-running 32-bit counter, wraps 0xFFFFFFFF->0. Any write clears it; the write wins over the increment.
  - 0xC STATUS: bit0 = bus_err. Writing bit0=1 clears bus_err, but a new error in the same cycle wins.
  - Other offsets: reads return 0, writes are ignored, bus_err is set.
- bus_err stays set until STATUS clear or reset.

Test Plan:
- RAM read: cpu_read=1, addr=0x0000_0100; ram_ack with ram_rdata=0x1234_5678 three cycles after ram_req -> cpu_rdata=0x1234_5678, one-cycle cpu_done, ram_req dropped, bus_err=0.
- GPIO: write 0xA5A5_0001 to 0xFFFF_0000 -> gpio_out=0xA5A5_0001 and done one cycle after accept. Then with gpio_in=0x0000_00FF, read 0xFFFF_0004 -> 0x0000_00FF.
- Timeout: RAM read with no ram_ack -> cpu_done exactly TIMEOUT+1 cycles after ram_req rises, cpu_rdata=0xDEAD_BEEF, bus_err=1. Write 1 to 0xFFFF_000C -> bus_err=0.
- Ack at the timeout edge: ram_ack asserted in cycle TIMEOUT with data 0x55 -> cpu_rdata=0x55, bus_err stays 0.
- Counter: write 0 to 0xFFFF_0008, then read after N cycles -> value matches the elapsed cycle count. Force 0xFFFF_FFFF -> wraps to 0.
- Reset mid-access: rst=1 during RAM_WAIT -> ram_req=0 next cycle, no cpu_done, all outputs 0. A new read after reset completes normally.
